instr_sequencer: RTL and testbench

Fetch/issue controller sitting between program memory and the `cpu` execute block. It owns the program counter, fetches 32-bit instruction words from memory into the instruction register and resolves NOP, BRA and HLT itself. All other opcodes are issued to `cpu`, and the sequencer waits for completion. While `cpu` executes, the sequencer hands the single memory port to `cpu`, so fetch and data accesses share one memory.

---
 rtl/instr_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_instr_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Fetch/issue controller: owns the PC, fetches instruction words, resolves NOP/BRA/HLT
// and issues everything else to the cpu, lending it the memory port. Optional SEQ_WDOG_EN adds an EXEC watchdog.
module instr_sequencer #(
    parameter int         BUSW  = 32,
    parameter int         MINDW = 12,
    parameter int         PSRW  = 5,
    parameter logic       REN   = 1'b0,
    parameter logic [3:0] NOP   = 4'h0,
    parameter logic [3:0] LD    = 4'h1,
    parameter logic [3:0] STR   = 4'h2,
    parameter logic [3:0] BRA   = 4'h3,
    parameter logic [3:0] XOR   = 4'h4,
    parameter logic [3:0] ADD   = 4'h5,
    parameter logic [3:0] ROT   = 4'h6,
    parameter logic [3:0] SHF   = 4'h7,
    parameter logic [3:0] HLT   = 4'h8,
    parameter logic [3:0] CMP   = 4'h9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [MINDW-1:0] MemInd,
    output logic             mrwen,
    output logic [BUSW-1:0]  MemDbusOut,
    input  logic [BUSW-1:0]  MemDbusIn,
    input  logic [MINDW-1:0] cpu_MemInd,
    input  logic             cpu_mrwen,
    input  logic [BUSW-1:0]  cpu_MemDbusOut,
    output logic [31:0]      IReg,
    output logic             ir_valid,
    input  logic             exec_done,
    input  logic [PSRW-1:0]  PsrIn,
    output logic [MINDW-1:0] ProgCnt,
    output logic             halted,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_FWAIT  = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [MINDW-1:0] pc_q, pc_d;
    logic [31:0]      ireg_q, ireg_d;
    logic             ir_valid_q, ir_valid_d;
    logic             halted_q, halted_d;

    logic [3:0]       opcode_s;
    logic [3:0]       cc_s;
    logic             bra_taken_s;
    logic [MINDW-1:0] pc_inc_s;
    logic             cpu_own_s;
    logic             unused_s;

`ifdef SEQ_WDOG_EN
    logic [7:0]       wdog_cnt_q, wdog_cnt_d;
    logic             err_q, err_d;
`endif

    assign opcode_s    = ireg_q[31:28];
    assign cc_s        = ireg_q[27:24];
    assign bra_taken_s = (cc_s == 4'h0) || ((cc_s & PsrIn[3:0]) != 4'h0);
    assign pc_inc_s    = pc_q + {{(MINDW-1){1'b0}}, 1'b1};
    assign unused_s    = ^{PsrIn, MemDbusIn};

    // Next-state and datapath update for the fetch/decode/issue sequence
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ireg_d     = ireg_q;
        ir_valid_d = 1'b0;
        halted_d   = halted_q;
`ifdef SEQ_WDOG_EN
        wdog_cnt_d = wdog_cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
                else       state_d = S_IDLE;
            end
            S_FETCH: state_d = S_FWAIT;
            S_FWAIT: begin
                ireg_d  = MemDbusIn[31:0];
                state_d = S_DECODE;
            end
            S_DECODE: begin
                // Issue is the common path; NOP/HLT/BRA override it below.
                pc_d       = pc_inc_s;
                ir_valid_d = 1'b1;
                state_d    = S_EXEC;
`ifdef SEQ_WDOG_EN
                wdog_cnt_d = 8'h00;
`endif
                case (opcode_s)
                    NOP: begin
                        ir_valid_d = 1'b0;
                        state_d    = S_FETCH;
                    end
                    HLT: begin
                        pc_d       = pc_q;
                        ir_valid_d = 1'b0;
                        halted_d   = 1'b1;
                        state_d    = S_HALT;
                    end
                    BRA: begin
                        ir_valid_d = 1'b0;
                        state_d    = S_FETCH;
                        if (bra_taken_s) pc_d = ireg_q[MINDW-1:0];
                        else             pc_d = pc_inc_s;
                    end
                    LD, STR, XOR, ADD, ROT, SHF, CMP: state_d = S_EXEC;
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                if (exec_done) begin
                    state_d = S_FETCH;
                end
`ifdef SEQ_WDOG_EN
                else if (wdog_cnt_q == 8'hFF) begin
                    err_d   = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    wdog_cnt_d = wdog_cnt_q + 8'h01;
                    state_d    = S_EXEC;
                end
`else
                else begin
                    state_d = S_EXEC;
                end
`endif
            end
            S_HALT: begin
                halted_d = 1'b1;
                state_d  = S_HALT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= {MINDW{1'b0}};
            ireg_q     <= 32'h0000_0000;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
`ifdef SEQ_WDOG_EN
            wdog_cnt_q <= 8'h00;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ireg_q     <= ireg_d;
            ir_valid_q <= ir_valid_d;
            halted_q   <= halted_d;
`ifdef SEQ_WDOG_EN
            wdog_cnt_q <= wdog_cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    // Memory port mux: cpu owns the port only during EXEC, and loses it as soon as rst rises
    assign cpu_own_s = (state_q == S_EXEC) && !rst;

    always_comb begin
        MemInd     = {MINDW{1'b0}};
        mrwen      = REN;
        MemDbusOut = {BUSW{1'b0}};
        if (cpu_own_s) begin
            MemInd     = cpu_MemInd;
            mrwen      = cpu_mrwen;
            MemDbusOut = cpu_MemDbusOut;
        end else if ((state_q == S_FETCH) && !rst) begin
            MemInd = pc_q;
        end else begin
            MemInd = {MINDW{1'b0}};
        end
    end

    assign IReg     = ireg_q;
    assign ir_valid = ir_valid_q;
    assign ProgCnt  = pc_q;
    assign halted   = halted_q;
`ifdef SEQ_WDOG_EN
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer with a 1-cycle-latency program memory.
module tb_instr_sequencer;

    localparam int   BUSW  = 32;
    localparam int   MINDW = 12;
    localparam int   PSRW  = 5;
    localparam logic REN   = 1'b0;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [MINDW-1:0] MemInd;
    logic             mrwen;
    logic [BUSW-1:0]  MemDbusOut;
    logic [BUSW-1:0]  MemDbusIn;
    logic [MINDW-1:0] cpu_MemInd;
    logic             cpu_mrwen;
    logic [BUSW-1:0]  cpu_MemDbusOut;
    logic [31:0]      IReg;
    logic             ir_valid;
    logic             exec_done;
    logic [PSRW-1:0]  PsrIn;
    logic [MINDW-1:0] ProgCnt;
    logic             halted;
    logic             err;

    logic [31:0] mem [0:4095];
    int n_cmp = 0;
    int n_bad = 0;

    instr_sequencer #(.BUSW(BUSW), .MINDW(MINDW), .PSRW(PSRW), .REN(REN)) dut (
        .clk(clk), .rst(rst), .start(start),
        .MemInd(MemInd), .mrwen(mrwen), .MemDbusOut(MemDbusOut), .MemDbusIn(MemDbusIn),
        .cpu_MemInd(cpu_MemInd), .cpu_mrwen(cpu_mrwen), .cpu_MemDbusOut(cpu_MemDbusOut),
        .IReg(IReg), .ir_valid(ir_valid), .exec_done(exec_done), .PsrIn(PsrIn),
        .ProgCnt(ProgCnt), .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) MemDbusIn <= mem[MemInd];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0000_0000;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; exec_done = 1'b0; PsrIn = '0;
        cpu_MemInd = '0; cpu_mrwen = 1'b0; cpu_MemDbusOut = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        clear_mem();
        do_reset();
        n_cmp++;
        if (ProgCnt !== 12'h000 || IReg !== 32'h0 || MemInd !== 12'h000 || mrwen !== REN ||
            MemDbusOut !== 32'h0 || ir_valid !== 1'b0 || halted !== 1'b0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_values: pc=%h ir=%h mi=%h rw=%b do=%h v=%b h=%b e=%b (want all 0, rw=%b)",
                     ProgCnt, IReg, MemInd, mrwen, MemDbusOut, ir_valid, halted, err, REN);
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            n_cmp++;
            if (MemInd !== 12'h000 || ProgCnt !== 12'h000 || IReg !== 32'h0) begin
                n_bad++;
                $display("FAIL idle_hold cyc %0d: mi=%h pc=%h ir=%h want 0", k, MemInd, ProgCnt, IReg);
            end
        end
    endtask

    task automatic test_nop_stream();
        logic [MINDW-1:0] exp_pc;
        clear_mem();
        mem[3] = 32'h8000_0000;
        do_reset();
        pulse_start();
        n_cmp++;
        if (MemInd !== 12'h000 || mrwen !== REN) begin
            n_bad++;
            $display("FAIL nop_first_fetch: mi=%h rw=%b want 000 %b", MemInd, mrwen, REN);
        end
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_pc = (k >= 9) ? 12'd3 : 12'(k / 3);
            n_cmp++;
            if (ProgCnt !== exp_pc || halted !== (k >= 12) || ir_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL nop_stream k=%0d: pc=%h halted=%b irv=%b want pc=%h halted=%b irv=0",
                         k, ProgCnt, halted, ir_valid, exp_pc, (k >= 12));
            end
            if (k == 3 || k == 6 || k == 9) begin
                n_cmp++;
                if (MemInd !== exp_pc) begin
                    n_bad++;
                    $display("FAIL nop_fetch_index k=%0d: mi=%h want %h", k, MemInd, exp_pc);
                end
            end
            if (k == 11) begin
                n_cmp++;
                if (IReg !== 32'h8000_0000) begin
                    n_bad++;
                    $display("FAIL hlt_ireg: ir=%h want 80000000", IReg);
                end
            end
        end
        start = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        start = 1'b0;
        n_cmp++;
        if (halted !== 1'b1 || ProgCnt !== 12'h003 || MemInd !== 12'h000) begin
            n_bad++;
            $display("FAIL halt_sticky: halted=%b pc=%h mi=%h want 1 003 000", halted, ProgCnt, MemInd);
        end
    endtask

    task automatic run_bra(input logic [31:0] instr, input logic [PSRW-1:0] psr,
                           input logic [MINDW-1:0] exp_pc, input string name);
        clear_mem();
        mem[0] = instr;
        do_reset();
        PsrIn = psr;
        pulse_start();
        tick();
        tick();
        tick();
        n_cmp++;
        if (ProgCnt !== exp_pc || MemInd !== exp_pc || ir_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: pc=%h mi=%h irv=%b want pc=mi=%h irv=0", name, ProgCnt, MemInd, ir_valid, exp_pc);
        end
    endtask

    task automatic test_bra();
        run_bra(32'h3100_0005, 5'b00001, 12'h005, "bra_taken");
        run_bra(32'h3100_0005, 5'b00000, 12'h001, "bra_not_taken");
        run_bra(32'h3100_0005, 5'b10000, 12'h001, "bra_psr4_ignored");
        run_bra(32'h3000_0007, 5'b00000, 12'h007, "bra_cc0_always");
        run_bra(32'h3C00_0123, 5'b01000, 12'h123, "bra_cc_bit3");
    endtask

    task automatic test_issue();
        clear_mem();
        mem[0] = 32'h1800_0003;
        do_reset();
        cpu_MemInd = 12'h00A;
        cpu_mrwen  = REN;
        pulse_start();
        n_cmp++;
        if (MemInd !== 12'h000) begin
            n_bad++;
            $display("FAIL issue_fetch_owner: mi=%h want 000", MemInd);
        end
        tick();
        tick();
        n_cmp++;
        if (ir_valid !== 1'b0 || IReg !== 32'h1800_0003) begin
            n_bad++;
            $display("FAIL issue_decode: irv=%b ir=%h want 0 18000003", ir_valid, IReg);
        end
        tick();
        n_cmp++;
        if (ir_valid !== 1'b1 || ProgCnt !== 12'h001 || MemInd !== 12'h00A || mrwen !== REN) begin
            n_bad++;
            $display("FAIL issue_exec1: irv=%b pc=%h mi=%h rw=%b want 1 001 00A %b",
                     ir_valid, ProgCnt, MemInd, mrwen, REN);
        end
        tick();
        cpu_mrwen      = ~REN;
        cpu_MemDbusOut = 32'hA5A5_5A5A;
        #1;
        n_cmp++;
        if (ir_valid !== 1'b0 || mrwen !== ~REN || MemDbusOut !== 32'hA5A5_5A5A || MemInd !== 12'h00A) begin
            n_bad++;
            $display("FAIL issue_exec2: irv=%b rw=%b do=%h mi=%h want 0 %b a5a55a5a 00A",
                     ir_valid, mrwen, MemDbusOut, MemInd, ~REN);
        end
        tick();
        tick();
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        cpu_mrwen = 1'b0;
        cpu_MemDbusOut = '0;
        n_cmp++;
        if (MemInd !== 12'h001 || ProgCnt !== 12'h001 || mrwen !== REN || MemDbusOut !== 32'h0 || ir_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL issue_return: mi=%h pc=%h rw=%b do=%h irv=%b want 001 001 %b 0 0",
                     MemInd, ProgCnt, mrwen, MemDbusOut, ir_valid, REN);
        end
    endtask

    task automatic test_back_to_back();
        clear_mem();
        mem[0] = 32'h1000_0000;
        mem[1] = 32'h3200_0009;
        do_reset();
        pulse_start();
        tick();
        tick();
        tick();
        exec_done = 1'b1;
        PsrIn = 5'b00010;
        tick();
        exec_done = 1'b0;
        tick();
        tick();
        tick();
        n_cmp++;
        if (ProgCnt !== 12'h009) begin
            n_bad++;
            $display("FAIL b2b_flag_branch: pc=%h want 009", ProgCnt);
        end
    endtask

    task automatic test_edges();
        clear_mem();
        mem[0] = 32'h3000_0FFF;
        do_reset();
        pulse_start();
        tick();
        tick();
        tick();
        n_cmp++;
        if (ProgCnt !== 12'hFFF) begin
            n_bad++;
            $display("FAIL wrap_setup: pc=%h want fff", ProgCnt);
        end
        tick();
        tick();
        tick();
        n_cmp++;
        if (ProgCnt !== 12'h000 || MemInd !== 12'h000) begin
            n_bad++;
            $display("FAIL pc_wrap: pc=%h mi=%h want 000 000", ProgCnt, MemInd);
        end
        clear_mem();
        mem[0] = 32'h1800_0003;
        do_reset();
        cpu_MemInd = 12'h00A;
        pulse_start();
        tick();
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (MemInd !== 12'h000) begin
            n_bad++;
            $display("FAIL rst_port_release: mi=%h want 000", MemInd);
        end
        tick();
        n_cmp++;
        if (MemInd !== 12'h000 || ProgCnt !== 12'h000 || IReg !== 32'h0 || ir_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_exec: mi=%h pc=%h ir=%h irv=%b want 0", MemInd, ProgCnt, IReg, ir_valid);
        end
        rst = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (MemInd !== 12'h000 || ProgCnt !== 12'h000) begin
            n_bad++;
            $display("FAIL rst_then_idle: mi=%h pc=%h want 000 000", MemInd, ProgCnt);
        end
        cpu_MemInd = '0;
    endtask

    task automatic test_watchdog();
        clear_mem();
        mem[0] = 32'h1800_0003;
        do_reset();
        cpu_MemInd = 12'h0AB;
        pulse_start();
        tick();
        tick();
        tick();
`ifdef SEQ_WDOG_EN
        for (int k = 0; k < 255; k++) tick();
        n_cmp++;
        if (err !== 1'b0 || MemInd !== 12'h0AB) begin
            n_bad++;
            $display("FAIL wdog_cycle256: err=%b mi=%h want 0 0ab", err, MemInd);
        end
        tick();
        n_cmp++;
        if (err !== 1'b1 || MemInd !== 12'h001 || ProgCnt !== 12'h001) begin
            n_bad++;
            $display("FAIL wdog_fire: err=%b mi=%h pc=%h want 1 001 001", err, MemInd, ProgCnt);
        end
        for (int k = 0; k < 10; k++) tick();
        n_cmp++;
        if (err !== 1'b1) begin
            n_bad++;
            $display("FAIL wdog_sticky: err=%b want 1", err);
        end
        do_reset();
        cpu_MemInd = 12'h0AB;
        pulse_start();
        tick();
        tick();
        tick();
        for (int k = 0; k < 255; k++) tick();
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        n_cmp++;
        if (err !== 1'b0 || MemInd !== 12'h001) begin
            n_bad++;
            $display("FAIL wdog_done_at_256: err=%b mi=%h want 0 001", err, MemInd);
        end
`else
        for (int k = 0; k < 1000; k++) begin
            tick();
            n_cmp++;
            if (err !== 1'b0 || MemInd !== 12'h0AB) begin
                n_bad++;
                $display("FAIL nowdog_wait k=%0d: err=%b mi=%h want 0 0ab", k, err, MemInd);
            end
        end
`endif
        cpu_MemInd = '0;
    endtask

    initial begin
        test_reset();
        test_nop_stream();
        test_bra();
        test_issue();
        test_back_to_back();
        test_edges();
        test_watchdog();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
